// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetches one instruction at a time from imem and queues {pc, word} for decode
//  clk          rising-edge clock
//  rst          asynchronous active-low reset
//  pc_in        fetch address from the program counter
//  pc_valid     pc_in is a fetch candidate this cycle
//  pc_stall     1 = address not accepted, PC must hold
//  flush        taken branch: drop queued words and the in-flight fetch
//  imem_req     read request to instruction memory, held until imem_ack
//  imem_addr    word-aligned read address
//  imem_ack     memory returns imem_rdata this cycle
//  imem_rdata   instruction word
//  instr_out    instruction at queue head (0 when empty)
//  instr_pc     PC of the instruction at queue head (0 when empty)
//  instr_valid  queue head valid
//  instr_ready  decode consumes the head when instr_valid=1
//  count        occupied queue entries, 0..DEPTH
module instruction_fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        pc_in,
   input  logic                     pc_valid,
   output logic                     pc_stall,
   input  logic                     flush,
   output logic                     imem_req,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic                     imem_ack,
   input  logic [DATA_W-1:0]        imem_rdata,
   output logic [DATA_W-1:0]        instr_out,
   output logic [ADDR_W-1:0]        instr_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
   state_t            state, state_nx;
   logic [ADDR_W-1:0] tag;
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [PW-1:0]     head, tail;
   logic              accept, push, pop;
   // stall is forced while reset is asserted so the PC never advances into a dead queue
   assign pc_stall    = !rst || !(state == IDLE && count != FULL && !flush);
   assign accept      = pc_valid && !pc_stall;
   // a word returning together with flush belongs to the abandoned path
   assign push        = state == REQ && imem_ack && !flush;
   assign pop         = instr_valid && instr_ready && !flush;
   // the request stays up through DISCARD: memory must see its ack before we let go
   assign imem_req    = state != IDLE;
   assign instr_valid = count != '0;
   assign instr_out   = instr_valid ? data_mem[head] : '0;
   assign instr_pc    = instr_valid ? pc_mem[head] : '0;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? REQ : IDLE;
         REQ:     state_nx = imem_ack ? IDLE : (flush ? DISCARD : REQ);
         DISCARD: state_nx = imem_ack ? IDLE : DISCARD;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         imem_addr <= '0;
         tag       <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            imem_addr <= {pc_in[ADDR_W-1:2], 2'b00};
            tag       <= pc_in;
         end
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + {PW'(0), push} - {PW'(0), pop};
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[tail] <= imem_rdata;
         pc_mem[tail]   <= tag;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: directed and random fetch traffic against a queue-based reference model
module tb_instruction_fetch_queue;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_stall;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  count;
   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] q[$];
   logic        busy, drop;
   logic [31:0] m_addr, m_tag;
   instruction_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_stall(pc_stall),
      .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .count(count)
   );
   always #5 clk = ~clk;
   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endfunction
   task automatic model_reset();
      q.delete();
      busy   = 1'b0;
      drop   = 1'b0;
      m_addr = '0;
      m_tag  = '0;
   endtask
   // Called just after a falling edge: drive, compare against the model, then advance the model across the rising edge.
   task automatic step(input logic pv, input logic [31:0] pc, input logic fl, input logic ak,
                       input logic [31:0] rd, input logic rdy);
      logic exp_stall, acc, do_pop;
      pc_valid = pv; pc_in = pc; flush = fl; imem_ack = ak; imem_rdata = rd; instr_ready = rdy;
      #1;
      exp_stall = !(!busy && q.size() < 4 && !fl);
      chk("pc_stall", 64'(pc_stall), 64'(exp_stall));
      chk("imem_req", 64'(imem_req), 64'(busy));
      chk("imem_addr", 64'(imem_addr), 64'(m_addr));
      chk("instr_valid", 64'(instr_valid), 64'(q.size() != 0));
      chk("count", 64'(count), 64'(q.size()));
      if (q.size() != 0) begin
         chk("instr_out", 64'(instr_out), 64'(q[0][31:0]));
         chk("instr_pc", 64'(instr_pc), 64'(q[0][63:32]));
      end
      acc    = pv && !exp_stall;
      do_pop = q.size() != 0 && rdy;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (busy && ak && !drop) q.push_back({m_tag, rd});
      end
      if (busy) begin
         if (ak) begin busy = 1'b0; drop = 1'b0; end
         else if (fl) drop = 1'b1;
      end else if (acc) begin
         busy   = 1'b1;
         m_addr = {pc[31:2], 2'b00};
         m_tag  = pc;
      end
      @(negedge clk);
   endtask
   initial begin
      logic ak;
      rst = 1'b0; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; imem_ack = 1'b0;
      imem_rdata = '0; instr_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_pc_stall", 64'(pc_stall), 64'd1);
      chk("rst_imem_req", 64'(imem_req), 64'd0);
      chk("rst_imem_addr", 64'(imem_addr), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      rst = 1'b1;
      // stream of three fetches consumed immediately
      step(1, 32'h0, 0, 0, 0, 1);
      chk("s1_req", 64'(imem_req), 64'd1);
      chk("s1_addr", 64'(imem_addr), 64'h0);
      step(0, 0, 0, 1, 32'h10620001, 1);
      chk("s1_out0", 64'(instr_out), 64'h10620001);
      chk("s1_pc0", 64'(instr_pc), 64'h0);
      step(1, 32'h4, 0, 0, 0, 1);
      step(0, 0, 0, 1, 32'h2, 1);
      chk("s1_pc1", 64'(instr_pc), 64'h4);
      step(1, 32'h8, 0, 0, 0, 1);
      step(0, 0, 0, 1, 32'h3, 1);
      chk("s1_out2", 64'(instr_out), 64'h3);
      chk("s1_pc2", 64'(instr_pc), 64'h8);
      step(0, 0, 0, 0, 0, 1);
      // misaligned fetch address
      step(1, 32'h6, 0, 0, 0, 0);
      chk("mis_addr", 64'(imem_addr), 64'h4);
      step(0, 0, 0, 1, 32'hdead, 0);
      chk("mis_pc", 64'(instr_pc), 64'h6);
      // fill to DEPTH with decode stalled
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h10 + 32'(4 * i), 0, 0, 0, 0);
         step(0, 0, 0, 1, 32'h100 + 32'(i), 0);
      end
      chk("full_count", 64'(count), 64'd4);
      step(1, 32'h50, 0, 0, 0, 0);
      chk("full_stall", 64'(pc_stall), 64'd1);
      chk("full_noreq", 64'(imem_req), 64'd0);
      step(0, 0, 0, 0, 0, 1);
      chk("pop_unstall", 64'(pc_stall), 64'd0);
      step(0, 0, 0, 0, 0, 1);
      // push and pop in the same cycle at count=2
      step(1, 32'h60, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h66, 1);
      chk("pp_count", 64'(count), 64'd2);
      // flush while a request is outstanding, ack arrives three cycles later
      step(0, 0, 1, 0, 0, 0);
      step(1, 32'h20, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("fl_req_held", 64'(imem_req), 64'd1);
      step(0, 0, 0, 0, 0, 1);
      step(1, 32'h30, 0, 0, 0, 1);
      chk("fl_req_held2", 64'(imem_req), 64'd1);
      step(0, 0, 0, 1, 32'hbad, 1);
      chk("fl_dropped", 64'(count), 64'd0);
      chk("fl_req_low", 64'(imem_req), 64'd0);
      step(1, 32'h40, 0, 0, 0, 0);
      chk("fl_next_addr", 64'(imem_addr), 64'h40);
      step(0, 0, 0, 1, 32'h44, 0);
      chk("fl_next_pc", 64'(instr_pc), 64'h40);
      // asynchronous reset between edges while a request is in flight
      step(1, 32'h100, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk("ar_req", 64'(imem_req), 64'd0);
      chk("ar_valid", 64'(instr_valid), 64'd0);
      chk("ar_count", 64'(count), 64'd0);
      chk("ar_stall", 64'(pc_stall), 64'd1);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step(1, 32'h0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 32'h77, 1);
      chk("ar_out", 64'(instr_out), 64'h77);
      chk("ar_pc", 64'(instr_pc), 64'h0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         ak = busy && ($urandom_range(0, 99) < 40);
         step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom_range(0, 99) < 6,
              ak, $urandom, $urandom_range(0, 99) < 55);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
